// File: rtl/muldiv_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_defs (package)
// Description : Shared state encodings, op-bit positions and default widths
//               for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_defs;
    localparam int c_default_width = 32;
    localparam int c_default_cnt_w = 5;

    localparam int c_op_signed_bit = 0;
    localparam int c_op_div_bit    = 1;
    localparam int c_op_w          = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration: shift-add multiply or restoring
//               shift-subtract divide on a 2W accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_defs::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_op_div,
    output logic [2*WIDTH-1:0] o_acc_next
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift_rem;
    logic [WIDTH:0] w_diff;

    // Multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}.
    always_comb begin
        w_sum       = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_shift_rem = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff      = w_shift_rem - {1'b0, i_operand};
        o_acc_next  = '0;
        if (!i_op_div) begin
            o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_acc_next = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc_next = {w_shift_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative signed/unsigned multiply/divide with HI/LO results,
//               busy/done handshake and pipeline cancel.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_defs::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_div;
    logic               r_neg_res;
    logic               r_neg_dvd;

    logic [c_op_w-1:0]  w_op;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op    = {op_div, op_signed};
    assign w_neg_a = w_op[c_op_signed_bit] & a[WIDTH-1];
    assign w_neg_b = w_op[c_op_signed_bit] & b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -a : a;
    assign w_mag_b = w_neg_b ? -b : b;

    // Remainder follows the dividend's sign; quotient/product follow a^b.
    assign w_prod   = r_neg_res ? -r_acc : r_acc;
    assign w_quo    = r_acc[WIDTH-1:0];
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_div ? (r_neg_dvd ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_div ? (r_neg_res ? -w_quo : w_quo) : w_prod[WIDTH-1:0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc      (r_acc),
        .i_operand  (r_opb),
        .i_op_div   (r_div),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_div       <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_dvd   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start && !cancel) begin
                        div_by_zero <= 1'b0;
                        if (w_op[c_op_div_bit] && (b == '0)) begin
                            r_state     <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi          <= a;
                            lo          <= '1;
                        end else begin
                            r_state   <= CALC;
                            busy      <= 1'b1;
                            r_count   <= '0;
                            r_div     <= w_op[c_op_div_bit];
                            r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opb     <= w_mag_b;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_dvd <= w_neg_a;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == c_last) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    r_state <= cancel ? IDLE : DONE;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        hi   <= w_fix_hi;
                        lo   <= w_fix_lo;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Directed-vector bench with an expected-result queue checked
//               by an independent done monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        op_signed = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    muldiv_iter #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_div      (op_div),
        .op_signed   (op_signed),
        .cancel      (cancel),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check({e.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Caller is at a negedge; start is held for exactly one rising edge.
    task automatic issue(input bit d, input bit s, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input bit ez, input int lat, input string name);
        exp_t e;
        if (push) begin
            e.hi = eh; e.lo = el; e.dbz = ez; e.cyc = cyc + lat; e.name = name;
            q.push_back(e);
        end
        op_div = d; op_signed = s; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    task automatic op(input bit d, input bit s, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el, input bit ez,
                      input int lat, input string name);
        @(negedge clk);
        issue(d, s, x, y, 1'b1, eh, el, ez, lat, name);
        drain();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b1;

        op(0, 0, 32'd7, 32'd6, 32'h0, 32'h2A, 0, 34, "multu_7x6");
        op(0, 1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, "mult_m3x5");
        op(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, 34, "multu_max");
        op(1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, "divu_100_7");
        op(1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, "div_m7_2");
        op(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34, "div_ovf");
        op(1, 0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1, 1, "divu_zero");
        op(1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, "dbz_clear");

        // Cancel when the counter reads 10: no result, outputs untouched.
        @(negedge clk);
        issue(0, 0, 32'd11, 32'd13, 1'b0, '0, '0, 0, 0, "");
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_done", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_hi", hi, 32'd2);
        check("cancel_lo", lo, 32'd14);

        // A second start while busy must not disturb the first operation.
        @(negedge clk);
        issue(0, 0, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, 0, 34, "busy_ignore");
        repeat (4) @(negedge clk);
        op_div = 1'b1; a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back: next start arrives in the DONE cycle.
        @(negedge clk);
        issue(0, 1, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34, "b2b_first");
        begin
            int n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", {31'd0, done}, 32'd1);
        end
        issue(1, 0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 0, 34, "b2b_second");
        drain();

        // Asynchronous reset at counter 20 clears outputs before any edge.
        @(negedge clk);
        issue(0, 0, 32'd5, 32'd5, 1'b0, '0, '0, 0, 0, "");
        repeat (20) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        op(0, 0, 32'd3, 32'd3, 32'd0, 32'd9, 0, 34, "after_rst_3x3");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage, in place of the single-cycle combinational mul/div path.
- Consumes the execute-stage operands (rs/rt values after forwarding) on a start pulse. Produces registered HI/LO results that the HI/LO read mux and writeback path use.
- Exposes busy/done so the hazard unit can stall mfhi/mflo and any back-to-back mul/div.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- op_div  in  1  0 = multiply, 1 = divide
- op_signed  in  1  0 = unsigned (multu/divu), 1 = signed (mult/div)
- cancel  in  1  pipeline flush; aborts the operation in flight
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high while in CALC or FIX
- done  out  1  one-cycle pulse; hi/lo valid
- div_by_zero  out  1  sticky flag for the last completed divide, cleared by the next accepted start
- hi  out  WIDTH  product[2W-1:W] or remainder
- lo  out  WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0. Internal operand/accumulator registers are cleared.
- Reset mid-operation aborts immediately; hi/lo go to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1 and cancel=0:
  - Latch the magnitudes |a| and |b| (two's-complement negate when op_signed and the MSB is set).
  - Latch the sign of the result and the sign of the dividend.
  - Set count=0 and go to CALC.
- Divide-by-zero exception: divide with b==0 goes directly to DONE. Result: hi=a (raw), lo={WIDTH{1}}, div_by_zero=1.
- DONE with no start goes to IDLE. done=1 only in DONE.
- CALC: one radix-2 step per cycle, count increments each cycle; on count==WIDTH-1 go to FIX.
  - Multiply: shift-add on a 2W accumulator.
  - Divide: restoring shift-subtract; quotient bit = no borrow.
- FIX:
  - Multiply: negate the 2W product if the result sign is negative.
  - Divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Then load hi/lo and go to DONE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E0+33 (WIDTH+1 edges). The divide-by-zero exception has done one cycle after E0.
- Outputs hold: hi/lo change only on entry to DONE (or reset) and hold until the next completion.
- Signed overflow: signed -2^(W-1) / -1 gives lo=0x80000000, hi=0. No trap; div_by_zero stays 0.
- start while busy: ignored, no state change. The hazard unit guarantees this never happens, but the block must tolerate it.
- cancel:
  - In CALC or FIX: return to IDLE next edge; hi/lo/div_by_zero unchanged; no done pulse.
  - In DONE: does not suppress the current done.
  - start together with cancel: start is ignored.
- start in DONE: accepted. done is high for that cycle only, then the unit is in CALC.
- busy and done are never high together.

Decomposition:
- Shared constants header muldiv_defs:
  - State encodings: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - Op bit positions.
  - Default WIDTH.
- One combinational sub-module, muldiv_step. It takes the accumulator, operand, and op_div, and returns the next accumulator (add-shift or subtract-shift with the quotient bit). This keeps the FSM module focused on control and counting.

Test Plan:
- multu a=7, b=6, start at E0 → busy 1 for 33 cycles, done pulse in cycle after E0+33, hi=0x00000000, lo=0x0000002A.
- mult signed a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- divu 100/7 → lo=14, hi=2. div signed -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 0x1234/0 → done one cycle after start, div_by_zero=1, hi=0x00001234, lo=0xFFFFFFFF. Next accepted start clears div_by_zero.
- Boundary events:
  - cancel at CALC count=10 → IDLE next cycle, no done, hi/lo keep the prior result.
  - start during busy → ignored, the original result completes at the original time.
  - start in DONE → back-to-back result 33 cycles later.
- rst asserted at CALC count=20 → busy=0, done=0, hi=lo=0 immediately (asynchronous, before the next edge). After release, a fresh multu 3×3 → lo=9.
